sha_padder_wide: RTL and testbench

- Parametrised SHA message padder. Accepts a byte stream IN_BYTES wide per beat and emits fully padded BLOCK_BITS-wide blocks: message, then 0x80, then zero fill, then a big-endian LEN_BITS bit-length field.
- Supports SHA-256 framing (512/64) and SHA-384/512 framing (1024/128).
- Supports multi-byte input beats, partial last beats and zero-length messages.
- Sits between the host byte interface and the compression core. Double-buffered so input can fill the next block while the core holds the current one.

---
 rtl/sha_padder_wide_if.sv | 28 ++
 rtl/sha_padder_wide.sv | 140 ++++++++++++++
 tb/tb_sha_padder_wide.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_padder_wide_if.sv
// Host-to-padder byte beats and padder-to-core block handshake.
// master = host/core side, slave = padder.
interface sha_padder_wide_if #(
  parameter int IN_BYTES   = 1,
  parameter int BLOCK_BITS = 512
);
  localparam int IB_W = $clog2(IN_BYTES + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [8*IN_BYTES-1:0] in_data;
  logic [IB_W-1:0]       in_bytes;
  logic                  in_last;
  logic                  blk_valid;
  logic                  blk_ready;
  logic [BLOCK_BITS-1:0] blk_data;
  logic                  blk_last;

  modport master (
    output in_valid, in_data, in_bytes, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/sha_padder_wide.sv
// SHA padder: packs byte beats into blocks, appends 0x80, zero fill, big-endian bit length.
// Final block valid 2 cycles after last beat (1-block tail); in_ready drops while asm is full or the tail is being built.
module sha_padder_wide #(
  parameter int IN_BYTES   = 1,
  parameter int BLOCK_BITS = 512,
  parameter int LEN_BITS   = 64
) (
  input logic             clk,
  input logic             rst,
  sha_padder_wide_if.slave bus
);
  localparam int BLOCK_BYTES = BLOCK_BITS / 8;
  localparam int LEN_BYTES   = LEN_BITS / 8;
  localparam int CNT_W       = $clog2(BLOCK_BYTES + 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0]      LEN_POS  = CNT_W'(BLOCK_BYTES - LEN_BYTES);
  localparam logic [BLOCK_BITS-1:0] PAD_BYTE = {8'h80, {(BLOCK_BITS-8){1'b0}}};

  typedef enum logic [1:0] {ACCUM, PAD, LENB, DONE} state_t;

  state_t                state_q, state_d;
  logic [BLOCK_BITS-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LEN_BITS-1:0]   bitlen_q, bitlen_d;
  logic                  asm_full_q, asm_full_d;
  logic                  asm_final_q, asm_final_d;
  logic                  blk_valid_q, blk_valid_d;
  logic [BLOCK_BITS-1:0] blk_data_q, blk_data_d;
  logic                  blk_last_q, blk_last_d;
  logic [BLOCK_BITS-1:0] beat_ext;
  logic                  in_ready;
  logic                  accept;
  logic                  xfer;

  assign in_ready = (state_q == ACCUM) && !asm_full_q && !rst;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = asm_full_q && (!blk_valid_q || bus.blk_ready);

  assign bus.in_ready  = in_ready;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_last  = blk_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      asm_q       <= '0;
      cnt_q       <= '0;
      bitlen_q    <= '0;
      asm_full_q  <= 1'b0;
      asm_final_q <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      bitlen_q    <= bitlen_d;
      asm_full_q  <= asm_full_d;
      asm_final_q <= asm_final_d;
      blk_valid_q <= blk_valid_d;
      blk_data_q  <= blk_data_d;
      blk_last_q  <= blk_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    bitlen_d    = bitlen_q;
    asm_full_d  = asm_full_q;
    asm_final_d = asm_final_q;
    blk_valid_d = blk_valid_q;
    blk_data_d  = blk_data_q;
    blk_last_d  = blk_last_q;

    // Beat left-aligned with invalid trailing bytes forced to zero, so it can be OR-ed in at cnt.
    beat_ext = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (i < int'(bus.in_bytes)) begin
        beat_ext[BLOCK_BITS-1-8*i -: 8] = bus.in_data[8*IN_BYTES-1-8*i -: 8];
      end
    end

    if (xfer) begin
      blk_data_d  = asm_q;
      blk_last_d  = asm_final_q;
      blk_valid_d = 1'b1;
      asm_d       = '0;
      cnt_d       = '0;
      asm_full_d  = 1'b0;
    end else if (blk_valid_q && bus.blk_ready) begin
      blk_valid_d = 1'b0;
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          asm_d    = asm_q | (beat_ext >> {cnt_q, 3'b000});
          cnt_d    = cnt_q + CNT_W'(bus.in_bytes);
          bitlen_d = bitlen_q + LEN_BITS'({bus.in_bytes, 3'b000});
          if (cnt_d == FULL_CNT) asm_full_d = 1'b1;
          if (bus.in_last) state_d = PAD;
        end
      end
      PAD: begin
        if (!asm_full_q) begin
          asm_d      = asm_q | (PAD_BYTE >> {cnt_q, 3'b000});
          asm_full_d = 1'b1;
          // Length only fits behind the 0x80 if at least LEN_BYTES bytes remain.
          if (cnt_q < LEN_POS) begin
            asm_d[LEN_BITS-1:0] = bitlen_q;
            asm_final_d         = 1'b1;
            state_d             = DONE;
          end else begin
            state_d = LENB;
          end
        end
      end
      LENB: begin
        if (!asm_full_q) begin
          asm_d       = {{(BLOCK_BITS-LEN_BITS){1'b0}}, bitlen_q};
          asm_full_d  = 1'b1;
          asm_final_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (xfer) begin
          bitlen_d    = '0;
          asm_final_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end
endmodule

// File: tb/tb_sha_padder_wide.sv
// Scoreboard bench for sha_padder_wide across four framings/beat widths.
// Stimulus pushes hand-computed blocks; a negedge monitor pops and compares on every presented block.
module tb_sha_padder_wide;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_padder_wide_if #(.IN_BYTES(1), .BLOCK_BITS(512))  if1 ();
  sha_padder_wide_if #(.IN_BYTES(4), .BLOCK_BITS(512))  if4 ();
  sha_padder_wide_if #(.IN_BYTES(8), .BLOCK_BITS(512))  if8 ();
  sha_padder_wide_if #(.IN_BYTES(8), .BLOCK_BITS(1024)) ifw ();

  sha_padder_wide #(.IN_BYTES(1), .BLOCK_BITS(512),  .LEN_BITS(64))  u1 (.clk(clk), .rst(rst), .bus(if1));
  sha_padder_wide #(.IN_BYTES(4), .BLOCK_BITS(512),  .LEN_BITS(64))  u4 (.clk(clk), .rst(rst), .bus(if4));
  sha_padder_wide #(.IN_BYTES(8), .BLOCK_BITS(512),  .LEN_BITS(64))  u8 (.clk(clk), .rst(rst), .bus(if8));
  sha_padder_wide #(.IN_BYTES(8), .BLOCK_BITS(1024), .LEN_BITS(128)) uw (.clk(clk), .rst(rst), .bus(ifw));

  logic [3:0]    o_vld, o_rdy, o_last, i_rdy, i_vld, i_lst;
  logic [1023:0] o_dat [4];
  logic [3:0]    i_nb  [4];

  assign o_vld  = {ifw.blk_valid, if8.blk_valid, if4.blk_valid, if1.blk_valid};
  assign o_rdy  = {ifw.blk_ready, if8.blk_ready, if4.blk_ready, if1.blk_ready};
  assign o_last = {ifw.blk_last,  if8.blk_last,  if4.blk_last,  if1.blk_last};
  assign i_rdy  = {ifw.in_ready,  if8.in_ready,  if4.in_ready,  if1.in_ready};
  assign i_vld  = {ifw.in_valid,  if8.in_valid,  if4.in_valid,  if1.in_valid};
  assign i_lst  = {ifw.in_last,   if8.in_last,   if4.in_last,   if1.in_last};
  assign o_dat[0] = {512'b0, if1.blk_data};
  assign o_dat[1] = {512'b0, if4.blk_data};
  assign o_dat[2] = {512'b0, if8.blk_data};
  assign o_dat[3] = ifw.blk_data;
  assign i_nb[0]  = 4'(if1.in_bytes);
  assign i_nb[1]  = 4'(if4.in_bytes);
  assign i_nb[2]  = 4'(if8.in_bytes);
  assign i_nb[3]  = ifw.in_bytes;

  typedef struct packed {
    logic [1:0]    id;
    logic          last;
    logic [1023:0] dat;
  } exp_t;
  exp_t sb [$];

  int asserts  = 0;
  int failures = 0;

  localparam logic [511:0]  ABC  = {32'h61626380, 416'b0, 64'h18};
  localparam logic [511:0]  ZERO = {8'h80, 504'b0};
  localparam logic [511:0]  AA1  = {{56{8'hAA}}, 8'h80, 56'b0};
  localparam logic [511:0]  AA2  = {448'b0, 64'h1C0};
  localparam logic [1023:0] W1   = {16{64'hDEADBEEF0BADF00D}};
  localparam logic [1023:0] W2   = {8'h80, 888'b0, 128'h400};

  function automatic int ib_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    asserts++;
    if (act !== exp) begin
      failures++;
      w = 0;
      for (int i = 0; i < 16; i++) if (act[64*i +: 64] !== exp[64*i +: 64]) w = i;
      $display("FAIL %s word %0d: got %h, required %h", name, w, act[64*w +: 64], exp[64*w +: 64]);
    end
  endtask

  task automatic push(input int k, input logic [1023:0] d, input bit l);
    exp_t e;
    e.id   = 2'(k);
    e.last = l;
    e.dat  = d;
    sb.push_back(e);
  endtask

  task automatic drive(input int k, input bit v, input logic [63:0] d, input int nb, input bit l);
    case (k)
      0: begin if1.in_valid = v; if1.in_data = d[63:56]; if1.in_bytes = 1'(nb); if1.in_last = l; end
      1: begin if4.in_valid = v; if4.in_data = d[63:32]; if4.in_bytes = 3'(nb); if4.in_last = l; end
      2: begin if8.in_valid = v; if8.in_data = d;        if8.in_bytes = 4'(nb); if8.in_last = l; end
      default: begin ifw.in_valid = v; ifw.in_data = d; ifw.in_bytes = 4'(nb); ifw.in_last = l; end
    endcase
  endtask

  // Returns #1 after the edge on which the beat was accepted.
  task automatic send(input int k, input logic [63:0] d, input int nb, input bit l);
    int c;
    drive(k, 1'b1, d, nb, l);
    c = 0;
    @(negedge clk);
    while (!i_rdy[k] && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (!i_rdy[k]) begin
      asserts++;
      failures++;
      $display("FAIL in_ready_timeout[%0d]: got 0 after %0d cycles, required 1", k, c);
    end
    @(posedge clk);
    #1;
    drive(k, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: checks presented blocks against the queue head; pops on acceptance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (i_vld[k] && !i_lst[k]) chk($sformatf("beat_bytes[%0d]", k), 64'(i_nb[k]), 64'(ib_of(k)));
        if (o_vld[k]) begin
          if (sb.size() == 0) begin
            asserts++;
            failures++;
            $display("FAIL unexpected_block[%0d]: got a valid block, required none", k);
          end else begin
            e = sb[0];
            chk($sformatf("blk_source[%0d]", k), 64'(k), 64'(e.id));
            chk_blk($sformatf("blk_data[%0d]", k), o_dat[k], e.dat);
            chk($sformatf("blk_last[%0d]", k), 64'(o_last[k]), 64'(e.last));
            if (o_rdy[k]) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, '0, 0, 1'b0);
    if1.blk_ready = 1'b1;
    if4.blk_ready = 1'b1;
    if8.blk_ready = 1'b1;
    ifw.blk_ready = 1'b1;

    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_blk_valid[%0d]", k), 64'(o_vld[k]), 64'd0);
      chk($sformatf("rst_blk_last[%0d]", k), 64'(o_last[k]), 64'd0);
      chk($sformatf("rst_in_ready[%0d]", k), 64'(i_rdy[k]), 64'd0);
      chk_blk($sformatf("rst_blk_data[%0d]", k), o_dat[k], '0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc", one byte per beat, with tail latency
    push(0, {512'b0, ABC}, 1'b1);
    send(0, {8'h61, 56'h0}, 1, 1'b0);
    send(0, {8'h62, 56'h0}, 1, 1'b0);
    send(0, {8'h63, 56'h0}, 1, 1'b1);
    @(negedge clk); chk("lat_n0", 64'(o_vld[0]), 64'd0);
    @(negedge clk); chk("lat_n1", 64'(o_vld[0]), 64'd0);
    @(negedge clk); chk("lat_n2", 64'(o_vld[0]), 64'd1);
    wait_drain("drain_abc1");

    // "abc" as one partial 4-byte beat
    push(1, {512'b0, ABC}, 1'b1);
    send(1, {32'h61626300, 32'h0}, 3, 1'b1);
    @(negedge clk); chk("in_ready_pad", 64'(i_rdy[1]), 64'd0);
    @(negedge clk); chk("in_ready_done", 64'(i_rdy[1]), 64'd0);
    @(negedge clk); chk("in_ready_back", 64'(i_rdy[1]), 64'd1);
    wait_drain("drain_abc4");

    // zero-length message
    push(0, {512'b0, ZERO}, 1'b1);
    send(0, 64'h0, 0, 1'b1);
    wait_drain("drain_zero");

    // 56 bytes: 0x80 lands where the length would go, so length spills to a second block
    push(2, {512'b0, AA1}, 1'b0);
    push(2, {512'b0, AA2}, 1'b1);
    for (int i = 0; i < 7; i++) send(2, {8{8'hAA}}, 8, i == 6);
    wait_drain("drain_aa");

    // exact 128-byte fill in 1024-bit framing, core stalls on block 1
    ifw.blk_ready = 1'b0;
    push(3, W1, 1'b0);
    push(3, W2, 1'b1);
    for (int i = 0; i < 16; i++) send(3, 64'hDEADBEEF0BADF00D, 8, i == 15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", i), 64'(o_vld[3]), 64'd1);
      chk($sformatf("stall_in_ready_%0d", i), 64'(i_rdy[3]), 64'd0);
    end
    @(posedge clk);
    #1 ifw.blk_ready = 1'b1;
    wait_drain("drain_wide");

    // reset mid-message discards the partial block
    for (int i = 0; i < 20; i++) send(0, {8'h55, 56'h0}, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_blk_valid", 64'(o_vld[0]), 64'd0);
    chk("midrst_in_ready", 64'(i_rdy[0]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    push(0, {512'b0, ABC}, 1'b1);
    send(0, {8'h61, 56'h0}, 1, 1'b0);
    send(0, {8'h62, 56'h0}, 1, 1'b0);
    send(0, {8'h63, 56'h0}, 1, 1'b1);
    wait_drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
